// File: rtl/fe25519_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fe25519_pkg: shared constants and types for GF(2^255-19) blocks   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package fe25519_pkg;

  localparam int FE_W   = 255;
  localparam int FOLD_C = 19;

  typedef logic [FE_W-1:0] fe_t;

  // p = 2^255 - 19: all ones except the low byte 0xED
  localparam fe_t P_MOD = {{(FE_W-5){1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    FINAL = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fe_fold19.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fe_fold19: y = x[254:0] + 19 * x[IN_W-1:255], combinational       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fe_fold19
  import fe25519_pkg::*;
#(
  parameter int IN_W = 256
) (
  input  logic [IN_W-1:0] x,
  output logic [FE_W:0]   y
);

  localparam int HI_W = IN_W - FE_W;
  localparam int PR_W = HI_W + 5;

  logic [HI_W-1:0] hi;
  logic [PR_W-1:0] prod;

  always_comb begin
    hi   = x[IN_W-1:FE_W];
    prod = {5'b00000, hi} * PR_W'(FOLD_C);
    y    = {1'b0, x[FE_W-1:0]} + {{(FE_W+1-PR_W){1'b0}}, prod};
  end

endmodule
`default_nettype wire

// File: rtl/femul_digit_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | femul_digit_serial: digit-serial multiplier/squarer mod 2^255-19  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module femul_digit_serial
  import fe25519_pkg::*;
#(
  parameter int DIGIT = 17,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sq,
  input  logic [FE_W-1:0]  in_a,
  input  logic [FE_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FE_W-1:0]  out_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NDIG = FE_W / DIGIT;
  localparam int K_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PP_W = FE_W + DIGIT;
  localparam int T_W  = FE_W + 2 + DIGIT;
  localparam logic [K_W-1:0] K_LAST = K_W'(NDIG - 1);

  state_t             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  fe_t                a_q, a_d;
  fe_t                b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [FE_W:0]      acc_q, acc_d;
  fe_t                out_r_q, out_r_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_valid_q, out_valid_d;
  logic               run_q;

  logic [DIGIT-1:0]   digit;
  logic [PP_W-1:0]    pp;
  logic [T_W-1:0]     t;
  logic [FE_W:0]      f1, f2;
  logic [FE_W:0]      r1;
  logic               ge1, ge2;
  fe_t                canon;

  // b is shifted left each MUL cycle, so the current digit is always its top slice
  always_comb begin
    digit = b_q[FE_W-1 -: DIGIT];
    pp    = {{DIGIT{1'b0}}, a_q} * {{FE_W{1'b0}}, digit};
    t     = {1'b0, acc_q, {DIGIT{1'b0}}} + {2'b00, pp};
  end

  fe_fold19 #(.IN_W(T_W))    u_fold_hi (.x(t),  .y(f1));
  fe_fold19 #(.IN_W(FE_W+1)) u_fold_lo (.x(f1), .y(f2));

  // acc < 2^255 + 19, so at most one subtract fires; the second keeps the canonical guarantee explicit
  always_comb begin
    ge1   = (acc_q >= {1'b0, P_MOD});
    r1    = ge1 ? (acc_q - {1'b0, P_MOD}) : acc_q;
    ge2   = (r1 >= {1'b0, P_MOD});
    canon = ge2 ? (r1[FE_W-1:0] - P_MOD) : r1[FE_W-1:0];
  end

  assign in_ready  = run_q && (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    acc_d       = acc_q;
    out_r_d     = out_r_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_sq ? in_a : in_b;
          tag_d   = in_tag;
          acc_d   = '0;
          k_d     = K_LAST;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = f2;
        b_d   = b_q << DIGIT;
        k_d   = k_q - K_W'(1);
        if (k_q == '0) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        out_r_d     = canon;
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      acc_q       <= '0;
      out_r_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      out_r_q     <= out_r_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      run_q       <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_femul_digit_serial.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_femul_digit_serial: directed + model-checked bench              |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_femul_digit_serial;
  import fe25519_pkg::*;

  localparam int DIGIT  = 17;
  localparam int TAG_W  = 4;
  localparam int NDIG   = FE_W / DIGIT;
  localparam int TMO    = 2000;
  localparam int N_RAND = 200;
  localparam int RST_AT = (NDIG > 8) ? 8 : 1;

  typedef logic [255:0] w_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sq = 1'b0;
  fe_t              in_a = '0;
  fe_t              in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  fe_t              out_r;
  logic [TAG_W-1:0] out_tag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  femul_digit_serial #(.DIGIT(DIGIT), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sq    (in_sq),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_tag  (out_tag)
  );

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent bit-serial double-and-add reference
  function automatic fe_t ref_mul(input fe_t a, input fe_t b);
    w_t pp, aa, r;
    pp = {1'b0, P_MOD};
    aa = {1'b0, a};
    if (aa >= pp) aa = aa - pp;
    r = '0;
    for (int i = FE_W - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= pp) r = r - pp;
      if (b[i]) begin
        r = r + aa;
        if (r >= pp) r = r - pp;
      end
    end
    return r[FE_W-1:0];
  endfunction

  function automatic fe_t rnd_fe();
    fe_t v;
    v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), 31'($urandom())};
    return v;
  endfunction

  task automatic send(input fe_t a, input fe_t b, input logic sq, input logic [TAG_W-1:0] tg);
    int waited;
    @(negedge clock);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sq    = sq;
    in_tag   = tg;
    waited   = 0;
    while (!in_ready && waited < TMO) begin
      @(negedge clock);
      waited++;
    end
    chk("accept", w_t'(in_ready), w_t'(1));
    last_acc = cyc;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_a     = '1;
    in_b     = '1;
    in_tag   = '1;
  endtask

  task automatic recv(input string nm, input fe_t exp_r, input logic [TAG_W-1:0] exp_tag,
                      input int exp_lat, input bit rnd);
    int lat;
    int gap;
    lat = 0;
    while (lat < TMO) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    chk({nm, "_valid"}, w_t'(out_valid), w_t'(1));
    if (exp_lat > 0) chk({nm, "_lat"}, w_t'(lat), w_t'(exp_lat));
    chk({nm, "_r"}, w_t'(out_r), w_t'(exp_r));
    chk({nm, "_tag"}, w_t'(out_tag), w_t'(exp_tag));
    gap = rnd ? $urandom_range(0, 3) : 0;
    out_ready = 1'b0;
    repeat (gap) @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input string nm, input fe_t a, input fe_t b, input logic sq,
                     input logic [TAG_W-1:0] tg, input fe_t exp_r, input int exp_lat);
    send(a, b, sq, tg);
    recv(nm, exp_r, tg, exp_lat, 1'b0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    fe_t two128, e, a, b;
    int  lat, acc1;
    bit  seen;
    logic sq;

    two128 = fe_t'(1) << 128;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_in_ready", w_t'(in_ready), w_t'(0));
    chk("rst_out_valid", w_t'(out_valid), w_t'(0));
    chk("rst_out_r", w_t'(out_r), w_t'(0));
    chk("rst_out_tag", w_t'(out_tag), w_t'(0));
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_in_ready", w_t'(in_ready), w_t'(1));

    // Directed vectors
    run("mul128", two128, two128, 1'b0, 4'h5, fe_t'(38), NDIG + 2);
    run("allones_x1", '1, fe_t'(1), 1'b0, 4'h1, fe_t'(18), 0);
    run("2p254_x2", fe_t'(1) << 254, fe_t'(2), 1'b0, 4'h2, fe_t'(19), 0);
    run("p_x7", P_MOD, fe_t'(7), 1'b0, 4'h3, fe_t'(0), 0);
    run("p_x1", P_MOD, fe_t'(1), 1'b0, 4'h9, fe_t'(0), 0);
    run("diff_sq", two128 - fe_t'(1), two128 + fe_t'(1), 1'b0, 4'h4, fe_t'(37), 0);
    run("sq128", two128, {85{3'b101}}, 1'b1, 4'h6, fe_t'(38), 0);
    e = (fe_t'(211) << 245) + fe_t'(3985634);
    run("sq_2p250", (fe_t'(1) << 250) - fe_t'(1997), '0, 1'b1, 4'h7, e, 0);
    run("zero_a", '0, {85{3'b110}}, 1'b0, 4'h8, fe_t'(0), 0);
    run("noncanon", P_MOD + fe_t'(5), fe_t'(3), 1'b0, 4'hA, fe_t'(15), 0);
    run("allones_sq", '1, '1, 1'b0, 4'hB, fe_t'(324), 0);

    // Initiation interval with out_ready answered immediately
    run("ii1", fe_t'(6), fe_t'(7), 1'b0, 4'h1, fe_t'(42), 0);
    acc1 = last_acc;
    run("ii2", fe_t'(8), fe_t'(9), 1'b0, 4'h2, fe_t'(72), 0);
    chk("ii", w_t'(last_acc - acc1), w_t'(NDIG + 3));

    // Backpressure: result held, new request refused
    send(fe_t'(3), fe_t'(5), 1'b0, 4'hA);
    lat = 0;
    while (!out_valid && lat < TMO) begin
      @(negedge clock);
      lat++;
    end
    chk("bp_valid", w_t'(out_valid), w_t'(1));
    in_valid = 1'b1;
    in_a     = fe_t'(100);
    in_b     = fe_t'(100);
    in_sq    = 1'b0;
    in_tag   = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_r", w_t'(out_r), w_t'(15));
      chk("bp_tag", w_t'(out_tag), w_t'(4'hA));
      chk("bp_in_ready", w_t'(in_ready), w_t'(0));
      chk("bp_hold_valid", w_t'(out_valid), w_t'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    run("after_bp", fe_t'(7), fe_t'(9), 1'b0, 4'hC, fe_t'(63), 0);

    // Reset mid-MUL aborts silently
    send(fe_t'(11), fe_t'(13), 1'b0, 4'hD);
    repeat (RST_AT) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_in_ready", w_t'(in_ready), w_t'(0));
    chk("mid_rst_out_valid", w_t'(out_valid), w_t'(0));
    chk("mid_rst_out_r", w_t'(out_r), w_t'(0));
    chk("mid_rst_out_tag", w_t'(out_tag), w_t'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mid_rel_in_ready", w_t'(in_ready), w_t'(1));
    seen = 1'b0;
    repeat (NDIG + 6) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_silent", w_t'(seen), w_t'(0));
    run("post_rst", two128, two128, 1'b0, 4'h3, fe_t'(38), NDIG + 2);

    // Random pairs against the reference model, random gaps on both sides
    for (int i = 0; i < N_RAND; i++) begin
      a  = rnd_fe();
      b  = rnd_fe();
      sq = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) a = '1;
      if ($urandom_range(0, 15) == 0) b = P_MOD;
      e  = ref_mul(a, sq ? a : b);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send(a, b, sq, 4'(i));
      recv("rnd", e, 4'(i), 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
